tiny_rv_mem: RTL and testbench

- Memory stage of the tiny_rv core, directly downstream of the execute stage.
- Takes the execute-stage result registers, performs RV32I loads and stores over a single-outstanding req/ack data bus, and registers the writeback bundle for the register file.
- Stalls the upstream pipe while a bus transaction is pending.
- Non-memory instructions pass through with one-cycle latency.

---
 rtl/tiny_rv_pkg.sv | 35 +++
 rtl/tiny_rv_lsu_align.sv | 65 ++++++
 rtl/tiny_rv_mem.sv | 187 ++++++++++++++++++
 tb/tb_tiny_rv_mem.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_rv_pkg.sv
// Shared constants and types for the tiny_rv memory stage.
package tiny_rv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Opcodes whose result is written back to rd (rd != 0 checked separately)
    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: writes_rd = 1'b1;
            default:                                                  writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_rv_lsu_align.sv
// Byte-lane steering for stores, access legality checks, and load
// lane extraction/extension. Purely combinational.
module tiny_rv_lsu_align
    import tiny_rv_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        acc_fault,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic        illegal;
    logic        misalign;
    logic [31:0] shifted;

    // Request side: legality, alignment, enables and replicated store data
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        be       = 4'b1111;
        wdata    = store_data;
        if (is_load) begin
            illegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                        funct3 == F3_LBU || funct3 == F3_LHU);
        end else if (is_store) begin
            illegal = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end
        case (funct3[1:0])
            2'd0: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                misalign = addr_lo[0];
                be       = 4'b0011 << addr_lo;
                wdata    = {2{store_data[15:0]}};
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
        acc_fault = (is_load || is_store) && (illegal || misalign);
    end

    // Response side: pick the addressed lane and extend
    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/tiny_rv_mem.sv
// tiny_rv memory stage: issues one load/store at a time on the data bus,
// stalls upstream while it is outstanding, and registers the writeback bundle.
module tiny_rv_mem
    import tiny_rv_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        pipe_stall,
    input  logic        exec_valid,
    input  logic [31:0] exec_pc,
    input  logic [31:0] exec_inst,
    input  logic [4:0]  exec_rd,
    input  logic [31:0] exec_rd_val,
    input  logic [31:0] exec_rs2_val,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic [4:0]  mem_rd,
    output logic [31:0] mem_rd_val,
    output logic        mem_rd_we,
    output logic        mem_fault
);

    localparam logic [31:0] TO_LAST = (BUS_TIMEOUT > 0) ? 32'(BUS_TIMEOUT - 1) : 32'd0;

    mem_state_t  state, state_next;
    logic [31:0] to_cnt;

    logic [31:0] pend_pc;
    logic [31:0] pend_inst;
    logic [4:0]  pend_rd;
    logic [2:0]  pend_funct3;
    logic [1:0]  pend_off;

    logic [6:0]  opc;
    logic        is_load, is_store, mem_op;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        acc_fault;
    logic [31:0] load_data;
    logic        to_hit;

    logic        do_issue, do_fault_now, do_ack, do_timeout;

    assign opc      = exec_inst[6:0];
    assign is_load  = (opc == OPC_LOAD);
    assign is_store = (opc == OPC_STORE);
    assign mem_op   = exec_valid && (is_load || is_store);
    assign to_hit   = (BUS_TIMEOUT != 0) && (to_cnt == TO_LAST);

    tiny_rv_lsu_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (exec_inst[14:12]),
        .addr_lo    (exec_rd_val[1:0]),
        .store_data (exec_rs2_val),
        .be         (be_c),
        .wdata      (wdata_c),
        .acc_fault  (acc_fault),
        .ld_funct3  (pend_funct3),
        .ld_off     (pend_off),
        .rdata      (i_dmem_rdata),
        .load_data  (load_data)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Next state, stall and datapath action selects
    always_comb begin
        state_next   = state;
        pipe_stall   = 1'b0;
        do_issue     = 1'b0;
        do_fault_now = 1'b0;
        do_ack       = 1'b0;
        do_timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (acc_fault) begin
                        do_fault_now = 1'b1;
                    end else begin
                        pipe_stall = 1'b1;
                        do_issue   = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ack wins over a timeout landing in the same cycle
                if (i_dmem_ack) begin
                    do_ack     = 1'b1;
                    state_next = IDLE;
                end else if (to_hit) begin
                    do_timeout = 1'b1;
                    state_next = IDLE;
                end else begin
                    pipe_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus registers, pending-transaction context and writeback bundle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            to_cnt       <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            pend_pc      <= '0;
            pend_inst    <= '0;
            pend_rd      <= '0;
            pend_funct3  <= '0;
            pend_off     <= '0;
            mem_valid    <= 1'b0;
            mem_pc       <= '0;
            mem_inst     <= '0;
            mem_rd       <= '0;
            mem_rd_val   <= '0;
            mem_rd_we    <= 1'b0;
            mem_fault    <= 1'b0;
        end else if (do_issue) begin
            to_cnt       <= '0;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= is_store;
            o_dmem_addr  <= {exec_rd_val[31:2], 2'b00};
            o_dmem_be    <= be_c;
            o_dmem_wdata <= wdata_c;
            pend_pc      <= exec_pc;
            pend_inst    <= exec_inst;
            pend_rd      <= exec_rd;
            pend_funct3  <= exec_inst[14:12];
            pend_off     <= exec_rd_val[1:0];
            mem_valid    <= 1'b0;
        end else if (do_ack || do_timeout) begin
            o_dmem_req <= 1'b0;
            mem_valid  <= 1'b1;
            mem_pc     <= pend_pc;
            mem_inst   <= pend_inst;
            mem_rd     <= pend_rd;
            mem_fault  <= do_timeout;
            if (do_ack && !o_dmem_we) begin
                mem_rd_val <= load_data;
                mem_rd_we  <= (pend_rd != 5'd0);
            end else begin
                mem_rd_val <= {o_dmem_addr[31:2], pend_off};
                mem_rd_we  <= 1'b0;
            end
        end else if (state == WAIT) begin
            to_cnt    <= to_cnt + 32'd1;
            mem_valid <= 1'b0;
        end else if (exec_valid) begin
            mem_valid <= 1'b1;
            mem_pc    <= exec_pc;
            mem_inst  <= exec_inst;
            mem_rd    <= exec_rd;
            if (do_fault_now) begin
                mem_rd_val <= exec_rd_val;
                mem_rd_we  <= 1'b0;
                mem_fault  <= 1'b1;
            end else begin
                mem_rd_val <= exec_rd_val;
                mem_rd_we  <= writes_rd(opc) && (exec_rd != 5'd0);
                mem_fault  <= 1'b0;
            end
        end else begin
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tiny_rv_mem.sv
// Directed bench for tiny_rv_mem: single-cycle vector table plus
// multi-cycle load/store, timeout and reset-in-WAIT sequences.
module tb_tiny_rv_mem;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        pipe_stall;
    logic        exec_valid;
    logic [31:0] exec_pc, exec_inst, exec_rd_val, exec_rs2_val;
    logic [4:0]  exec_rd;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        mem_valid, mem_rd_we, mem_fault;
    logic [31:0] mem_pc, mem_inst, mem_rd_val;
    logic [4:0]  mem_rd;

    int tests  = 0;
    int failed = 0;

    always #5 i_clk = ~i_clk;

    tiny_rv_mem #(.BUS_TIMEOUT(4)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .pipe_stall   (pipe_stall),
        .exec_valid   (exec_valid),
        .exec_pc      (exec_pc),
        .exec_inst    (exec_inst),
        .exec_rd      (exec_rd),
        .exec_rd_val  (exec_rd_val),
        .exec_rs2_val (exec_rs2_val),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .mem_valid    (mem_valid),
        .mem_pc       (mem_pc),
        .mem_inst     (mem_inst),
        .mem_rd       (mem_rd),
        .mem_rd_val   (mem_rd_val),
        .mem_rd_we    (mem_rd_we),
        .mem_fault    (mem_fault)
    );

    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                           O_OPI = 7'b0010011, O_LUI = 7'b0110111, O_JAL = 7'b1101111,
                           O_BR = 7'b1100011;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] rd_val;
        logic        ack;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic        e_we;
        logic [31:0] e_val;
        logic        e_fault;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [4:0] rd);
        mk_inst = {17'd0, f3, rd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input logic [31:0] inst, input logic [4:0] rd,
                           input logic [31:0] val, input logic ack, input logic ev, input logic [4:0] erd,
                           input logic ewe, input logic [31:0] eval, input logic ef, input logic [31:0] epc);
        vecs[i] = '{v, inst, rd, val, ack, ev, erd, ewe, eval, ef, epc};
    endtask

    // One load/store through the bus with 'waits' ack-less WAIT cycles
    task automatic run_mem(input string nm, input logic [31:0] inst, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] rs2, input int waits,
                           input logic [31:0] rdata, input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic e_we, input logic chk_val,
                           input logic [31:0] e_val, input logic e_rd_we, input logic [31:0] pc);
        int stalls;
        stalls = 0;
        @(negedge i_clk);
        exec_valid = 1'b1; exec_inst = inst; exec_rd = rd; exec_rd_val = addr;
        exec_rs2_val = rs2; exec_pc = pc; i_dmem_ack = 1'b0;
        #1;
        if (pipe_stall) stalls++;
        @(posedge i_clk); #1;
        chk({nm, "_req"}, o_dmem_req, 1'b1);
        chk({nm, "_addr"}, o_dmem_addr, e_addr);
        chk({nm, "_be"}, o_dmem_be, e_be);
        chk({nm, "_we"}, o_dmem_we, e_we);
        if (e_we) chk({nm, "_wdata"}, o_dmem_wdata, e_wdata);
        chk({nm, "_bubble"}, mem_valid, 1'b0);
        for (int i = 0; i <= waits; i++) begin
            @(negedge i_clk);
            i_dmem_ack = (i == waits); i_dmem_rdata = rdata;
            #1;
            if (pipe_stall) stalls++;
            chk({nm, "_req_held"}, o_dmem_req, 1'b1);
            @(posedge i_clk); #1;
            exec_valid = 1'b0; i_dmem_ack = 1'b0;
        end
        chk({nm, "_stall_cycles"}, stalls, waits + 1);
        chk({nm, "_req_drop"}, o_dmem_req, 1'b0);
        chk({nm, "_valid"}, mem_valid, 1'b1);
        chk({nm, "_pc"}, mem_pc, pc);
        chk({nm, "_rd_we"}, mem_rd_we, e_rd_we);
        chk({nm, "_fault"}, mem_fault, 1'b0);
        if (chk_val) chk({nm, "_rd_val"}, mem_rd_val, e_val);
    endtask

    initial begin
        i_reset = 1'b1; exec_valid = 1'b0; exec_pc = '0; exec_inst = '0; exec_rd = '0;
        exec_rd_val = '0; exec_rs2_val = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;

        //      i   v   inst                      rd   rd_val        ack ev  erd we  e_val         f   e_pc
        set_vec(0,  1, mk_inst(O_OP,    3'd0, 5),  5, 32'h0000_1234, 0, 1,  5, 1, 32'h0000_1234, 0, 32'h1000);
        set_vec(1,  1, mk_inst(O_OPI,   3'd0, 0),  0, 32'h0000_0077, 0, 1,  0, 0, 32'h0000_0077, 0, 32'h1004);
        set_vec(2,  1, mk_inst(O_LUI,   3'd0, 7),  7, 32'hABCD_E000, 1, 1,  7, 1, 32'hABCD_E000, 0, 32'h1008);
        set_vec(3,  1, mk_inst(O_BR,    3'd0, 3),  3, 32'h0000_0055, 0, 1,  3, 0, 32'h0000_0055, 0, 32'h100C);
        set_vec(4,  1, mk_inst(O_LOAD,  3'd2, 9),  9, 32'h0000_0101, 0, 1,  9, 0, 32'h0000_0101, 1, 32'h1010);
        set_vec(5,  1, mk_inst(O_LOAD,  3'd1, 9),  9, 32'h0000_0203, 0, 1,  9, 0, 32'h0000_0203, 1, 32'h1014);
        set_vec(6,  1, mk_inst(O_LOAD,  3'd3, 9),  9, 32'h0000_0100, 0, 1,  9, 0, 32'h0000_0100, 1, 32'h1018);
        set_vec(7,  1, mk_inst(O_STORE, 3'd2, 0),  0, 32'h0000_0102, 0, 1,  0, 0, 32'h0000_0102, 1, 32'h101C);
        set_vec(8,  1, mk_inst(O_STORE, 3'd3, 0),  0, 32'h0000_0100, 0, 1,  0, 0, 32'h0000_0100, 1, 32'h1020);
        set_vec(9,  0, mk_inst(O_OP,    3'd0, 4),  4, 32'h0000_0999, 0, 0,  0, 0, 32'h0000_0100, 1, 32'h1020);
        set_vec(10, 1, mk_inst(O_JAL,   3'd0, 1),  1, 32'h0000_0040, 0, 1,  1, 1, 32'h0000_0040, 0, 32'h1028);

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req", o_dmem_req, 1'b0);
        chk("rst_valid", mem_valid, 1'b0);
        chk("rst_rd_val", mem_rd_val, 32'd0);
        chk("rst_rd_we", mem_rd_we, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        chk("rst_stall", pipe_stall, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk);
            exec_valid = vecs[i].valid; exec_inst = vecs[i].inst; exec_rd = vecs[i].rd;
            exec_rd_val = vecs[i].rd_val; exec_pc = 32'h1000 + 32'(i * 4);
            exec_rs2_val = 32'h5A5A_5A5A; i_dmem_ack = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_stall", i), pipe_stall, 1'b0);
            @(posedge i_clk); #1;
            chk($sformatf("v%0d_valid", i), mem_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_rd", i), mem_rd, vecs[i].e_rd);
            chk($sformatf("v%0d_rd_we", i), mem_rd_we, vecs[i].e_we);
            chk($sformatf("v%0d_rd_val", i), mem_rd_val, vecs[i].e_val);
            chk($sformatf("v%0d_fault", i), mem_fault, vecs[i].e_fault);
            chk($sformatf("v%0d_pc", i), mem_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_noreq", i), o_dmem_req, 1'b0);
        end
        @(negedge i_clk);
        exec_valid = 1'b0; i_dmem_ack = 1'b0;

        run_mem("lw",  mk_inst(O_LOAD, 3'd2, 10), 10, 32'h100, 32'h0, 0, 32'hDEAD_BEEF,
                32'h100, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h2000);
        run_mem("lb",  mk_inst(O_LOAD, 3'd0, 11), 11, 32'h103, 32'h0, 3, 32'h80FF_FF7F,
                32'h100, 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 32'h2004);
        run_mem("lbu", mk_inst(O_LOAD, 3'd4, 12), 12, 32'h103, 32'h0, 3, 32'h80FF_FF7F,
                32'h100, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h2008);
        run_mem("lh",  mk_inst(O_LOAD, 3'd1, 13), 13, 32'h102, 32'h0, 1, 32'h8001_1234,
                32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b1, 32'h200C);
        run_mem("lhu", mk_inst(O_LOAD, 3'd5, 0),  0,  32'h102, 32'h0, 0, 32'h8001_1234,
                32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1'b0, 32'h2010);
        run_mem("sh",  mk_inst(O_STORE, 3'd1, 0), 0,  32'h202, 32'hABCD_1234, 1, 32'h0,
                32'h200, 4'b1100, 32'h1234_1234, 1'b1, 1'b0, 32'h0, 1'b0, 32'h2014);
        run_mem("sb",  mk_inst(O_STORE, 3'd0, 0), 0,  32'h301, 32'h1234_56A5, 0, 32'h0,
                32'h300, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0, 1'b0, 32'h2018);

        // Timeout: four ack-less WAIT cycles, then fault retirement
        @(negedge i_clk);
        exec_valid = 1'b1; exec_inst = mk_inst(O_LOAD, 3'd2, 6); exec_rd = 6;
        exec_rd_val = 32'h300; exec_pc = 32'h3000; i_dmem_ack = 1'b0;
        @(posedge i_clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk); #1;
            chk($sformatf("to_req_c%0d", i), o_dmem_req, 1'b1);
            chk($sformatf("to_stall_c%0d", i), pipe_stall, (i < 3) ? 1'b1 : 1'b0);
            @(posedge i_clk); #1;
            if (i == 3) exec_valid = 1'b0;
        end
        chk("to_req_drop", o_dmem_req, 1'b0);
        chk("to_valid", mem_valid, 1'b1);
        chk("to_fault", mem_fault, 1'b1);
        chk("to_rd_we", mem_rd_we, 1'b0);

        // Reset while a transaction is outstanding
        @(negedge i_clk);
        exec_valid = 1'b1; exec_inst = mk_inst(O_LOAD, 3'd2, 6); exec_rd = 6;
        exec_rd_val = 32'h400; exec_pc = 32'h4000;
        @(posedge i_clk); #1;
        chk("rw_req_up", o_dmem_req, 1'b1);
        @(negedge i_clk);
        i_reset = 1'b1; exec_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("rw_req", o_dmem_req, 1'b0);
        chk("rw_valid", mem_valid, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Stage still passes a plain instruction after the abandoned transaction
        exec_valid = 1'b1; exec_inst = mk_inst(O_OP, 3'd0, 8); exec_rd = 8;
        exec_rd_val = 32'h0000_0BAD; exec_pc = 32'h5000; i_dmem_ack = 1'b1;
        #1;
        chk("post_stall", pipe_stall, 1'b0);
        @(posedge i_clk); #1;
        chk("post_valid", mem_valid, 1'b1);
        chk("post_rd_val", mem_rd_val, 32'h0000_0BAD);
        chk("post_noreq", o_dmem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
